instr_encoder_loader: RTL
=========================

Name: instr_encoder_loader

Overview:
- Encoder counterpart of the processor's control decoder. Accepts symbolic instructions (kind plus register/immediate fields) over a valid/ready handshake.
- Packs each one into a 32-bit RV32I word and writes it into instruction memory at an auto-incrementing address.
- Used to load test programs for the single-cycle datapath. Supports exactly the decoded subset: ADD, SUB, AND, OR, SLT, ADDI, LW, SW.

Parameters:
- ADDR_W, 6: instruction-memory word-address width; capacity 2^ADDR_W words.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- clear  in  1  synchronous restart: pointer and count to 0, state to IDLE.
- in_valid  in  1  instruction fields valid.
- in_ready  out  1  encoder can accept.
- kind  in  4  0 ADD, 1 SUB, 2 AND, 3 OR, 4 SLT, 5 ADDI, 6 LW, 7 SW, 8-15 illegal.
- rd  in  5  destination register.
- rs1  in  5  source register 1.
- rs2  in  5  source register 2.
- imm  in  12  immediate, two's complement.
- finish  in  1  end of program.
- imem_we  out  1  instruction-memory write strobe.
- imem_addr  out  ADDR_W  word address.
- imem_wdata  out  32  encoded instruction.
- count  out  ADDR_W+1  words written.
- full  out  1  count == 2^ADDR_W.
- err  out  1  one-cycle pulse on illegal kind.
- done  out  1  program closed.

Behaviour:
- Reset state: IDLE, pointer 0, count 0. All outputs 0 except in_ready.
- in_ready: 1 only in IDLE with !full and !finish.
- States: IDLE, WRITE, ERR, DONE (plus TERM, see Optional Feature).
- Outputs are registered.
- IDLE:
  - in_valid && in_ready: latch fields. Legal kind -> WRITE; illegal kind -> ERR.
  - finish=1: go to DONE. finish has priority over in_valid; the instruction is not accepted.
- WRITE, one cycle:
  - imem_we=1, imem_addr=pointer, imem_wdata=encoded word.
  - At the end of the cycle: pointer+1, count+1, return to IDLE.
  - Latency: accept edge N -> imem_we high during cycle N+1. Throughput is one instruction per 2 cycles.
- ERR, one cycle: err=1, imem_we=0, pointer and count unchanged, then IDLE.
- DONE: done=1, in_ready=0, imem_we=0. Stays in DONE until clear or rst.
- Encoding:
  - R-type: funct7|rs2|rs1|funct3|rd|0110011.
    - ADD: f3 000, f7 0000000.
    - SUB: f3 000, f7 0100000.
    - AND: f3 111.
    - OR: f3 110.
    - SLT: f3 010.
  - ADDI: imm|rs1|000|rd|0010011.
  - LW: imm|rs1|010|rd|0000011.
  - SW: imm[11:5]|rs2|rs1|010|imm[4:0]|0100011.
  - Fields not used by a kind are ignored.
- Full:
  - When count reaches 2^ADDR_W: full=1 and in_ready=0.
  - The pointer does not wrap; no overwrite.
  - finish is still honoured while full.
- clear:
  - Highest-priority synchronous event. Aborts WRITE/ERR/TERM in the same cycle (imem_we forced 0).
  - Clears done, full, count and pointer.
- rst asserted mid-WRITE: imem_we drops to 0 immediately (async); no partial write completes.

Optional Feature:
- Macro: ENC_EBREAK_TERM_EN.
- Defined:
  - finish in IDLE with !full goes to state TERM.
  - TERM writes 0x00100073 (EBREAK) at the pointer, increments pointer and count, then enters DONE.
  - If full, goes straight to DONE with no write.
- Undefined: finish goes directly to DONE; no terminator word is written.

Test Plan:
- rst, then ADD rd=3 rs1=1 rs2=2 -> imem_we one cycle later, addr 0, wdata 0x002081B3, count 1.
- SUB rd=5 rs1=6 rs2=7, then LW rd=4 rs1=2 imm=8 -> addr 0: 0x407302B3; addr 1: 0x00812203; in_ready low on each WRITE cycle.
- SW rs2=5 rs1=0 imm=0xFFC -> wdata 0xFE502E23.
- ADDR_W=2, five back-to-back ADDI -> writes at addr 0-3, full=1, fifth held with in_ready=0; clear -> count 0, in_ready=1.
- kind=9 with valid -> err pulse one cycle, no imem_we, count unchanged; finish with in_valid in the same cycle -> DONE, instruction not written.
- rst mid-WRITE -> imem_we 0 asynchronously, count 0. With ENC_EBREAK_TERM_EN defined, finish after 2 instructions -> addr 2 gets 0x00100073, count 3, done=1.

Source files
------------

// File: rtl/instr_encoder_loader.sv
// instr_encoder_loader: packs symbolic RV32I instructions (ADD, SUB, AND, OR,
// SLT, ADDI, LW, SW) into 32-bit words and writes them into instruction memory
// at an auto-incrementing word address.
// Optional build macro ENC_EBREAK_TERM_EN: on finish, append an EBREAK
// terminator word before closing the program.
module instr_encoder_loader #(
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        kind,
    input  logic [4:0]        rd,
    input  logic [4:0]        rs1,
    input  logic [4:0]        rs2,
    input  logic [11:0]       imm,
    input  logic              finish,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              err,
    output logic              done
);

    typedef enum logic [2:0] {
        S_IDLE, S_WRITE, S_ERR, S_DONE, S_TERM
    } state_t;

    localparam logic [ADDR_W:0] CAP    = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [31:0]     EBREAK = 32'h0010_0073;

    state_t          state, state_nxt;
    logic [ADDR_W:0] count_q, count_nxt;
    logic [31:0]     wdata_q, wdata_nxt;
    logic [31:0]     enc_word;
    logic            enc_legal;

    // The pointer never wraps and always equals the number of words written,
    // so one counter serves as both; its low bits are the write address.
    assign count      = count_q;
    assign imem_addr  = count_q[ADDR_W-1:0];
    assign imem_wdata = wdata_q;
    assign full       = (count_q == CAP);
    assign done       = (state == S_DONE);
    // clear aborts a write/error cycle already in flight
    assign imem_we    = ((state == S_WRITE) || (state == S_TERM)) && !clear;
    assign err        = (state == S_ERR) && !clear;
    assign in_ready   = (state == S_IDLE) && !full && !finish;

    // Combinational RV32I packing of the current input fields
    always_comb begin
        enc_legal = 1'b1;
        enc_word  = 32'h0;
        case (kind)
            4'd0: enc_word = {7'b0000000, rs2, rs1, 3'b000, rd, 7'b0110011};
            4'd1: enc_word = {7'b0100000, rs2, rs1, 3'b000, rd, 7'b0110011};
            4'd2: enc_word = {7'b0000000, rs2, rs1, 3'b111, rd, 7'b0110011};
            4'd3: enc_word = {7'b0000000, rs2, rs1, 3'b110, rd, 7'b0110011};
            4'd4: enc_word = {7'b0000000, rs2, rs1, 3'b010, rd, 7'b0110011};
            4'd5: enc_word = {imm, rs1, 3'b000, rd, 7'b0010011};
            4'd6: enc_word = {imm, rs1, 3'b010, rd, 7'b0000011};
            4'd7: enc_word = {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
            default: enc_legal = 1'b0;
        endcase
    end

    // Next-state, pointer and latched-word logic; clear overrides everything
    always_comb begin
        state_nxt = state;
        count_nxt = count_q;
        wdata_nxt = wdata_q;
        case (state)
            S_IDLE: begin
                if (finish) begin
`ifdef ENC_EBREAK_TERM_EN
                    if (!full) begin
                        state_nxt = S_TERM;
                        wdata_nxt = EBREAK;
                    end else begin
                        state_nxt = S_DONE;
                    end
`else
                    state_nxt = S_DONE;
`endif
                end else if (in_valid && !full) begin
                    if (enc_legal) begin
                        state_nxt = S_WRITE;
                        wdata_nxt = enc_word;
                    end else begin
                        state_nxt = S_ERR;
                    end
                end
            end
            S_WRITE: begin
                count_nxt = count_q + 1'b1;
                state_nxt = S_IDLE;
            end
            S_TERM: begin
                count_nxt = count_q + 1'b1;
                state_nxt = S_DONE;
            end
            S_ERR:   state_nxt = S_IDLE;
            S_DONE:  state_nxt = S_DONE;
            default: state_nxt = S_IDLE;
        endcase
        if (clear) begin
            state_nxt = S_IDLE;
            count_nxt = '0;
        end
    end

    // State, counter and output-word registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            count_q <= '0;
            wdata_q <= '0;
        end else begin
            state   <= state_nxt;
            count_q <= count_nxt;
            wdata_q <= wdata_nxt;
        end
    end

endmodule
